// File: rtl/spi_mstr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_mstr_pkg
// Description : Shared types and default constants for the SPI master
//               generator (state encoding, frame length, SCLK divider).
// Revision    : 1.0 - initial release
// ============================================================================
package spi_mstr_pkg;

    // Default frame length in bits (legal range 8..32).
    localparam int c_WIDTH_DFLT    = 16;

    // Default clk cycles per SCLK period (even, >= 4).
    localparam int c_SCLK_DIV_DFLT = 32;

    // Transaction phases: idle, front porch (SCLK high after SS_n falls),
    // bit shifting, back porch (SCLK high before SS_n rises).
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRONT = 2'd1,
        SHIFT = 2'd2,
        BACK  = 2'd3
    } spi_state_t;

endpackage : spi_mstr_pkg
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module      : spi_sclk_gen
// Description : SCLK divider for the SPI master. Counts half periods of SCLK
//               while running, toggles SCLK at each half-period boundary and
//               emits single-cycle rise/fall strobes that coincide with the
//               clk edge on which SCLK changes. With hold asserted, the
//               falling half-period boundary is still reported but SCLK stays
//               high (used for the back porch).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sclk_gen
    import spi_mstr_pkg::*;
#(
    parameter int SCLK_DIV = c_SCLK_DIV_DFLT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_run,
    input  logic i_hold,
    output logic o_sclk,
    output logic o_rise,
    output logic o_fall
);

    localparam int              c_HALF = SCLK_DIV / 2;
    localparam int              c_CW   = (c_HALF > 1) ? $clog2(c_HALF) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_HALF - 1);

    logic [c_CW-1:0] r_cnt;
    logic            r_sclk;
    logic            w_tick;

    // A half-period boundary is reached on the last count of the divider.
    assign w_tick = i_run && (r_cnt == c_LAST);

    // Divider counter and SCLK level; clearing restarts a fresh, high period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_sclk <= 1'b1;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_sclk <= 1'b1;
        end else if (i_run) begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick) begin
                if (!r_sclk) begin
                    r_sclk <= 1'b1;
                end else if (!i_hold) begin
                    r_sclk <= 1'b0;
                end
            end
        end
    end

    assign o_sclk = r_sclk;
    assign o_rise = w_tick && !r_sclk;
    assign o_fall = w_tick &&  r_sclk;

endmodule : spi_sclk_gen
`default_nettype wire

// File: rtl/spi_mstr_gen.sv
`default_nettype none
// ============================================================================
// Module      : spi_mstr_gen
// Description : SPI master (CPOL=1, CPHA=1 style). A wrt pulse in IDLE loads
//               cmd and runs one WIDTH-bit frame, MSB first: MISO is sampled
//               on each SCLK rise, the shift register advances on each SCLK
//               fall after the first and once more at the end of the back
//               porch. done is sticky until the next accepted wrt.
//               Optional feature macro: SPI_MSTR_OVR_EN adds the sticky
//               overrun flag ovr (wrt seen while busy).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_mstr_gen
    import spi_mstr_pkg::*;
#(
    parameter int WIDTH    = c_WIDTH_DFLT,
    parameter int SCLK_DIV = c_SCLK_DIV_DFLT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wrt,
    input  logic [WIDTH-1:0] cmd,
    input  logic             MISO,
    output logic             SS_n,
    output logic             SCLK,
    output logic             MOSI,
`ifdef SPI_MSTR_OVR_EN
    output logic             ovr,
`endif
    output logic             done,
    output logic [WIDTH-1:0] rd_data
);

    localparam int               c_RCW   = $clog2(WIDTH + 1);
    localparam logic [c_RCW-1:0] c_NBITS = c_RCW'(WIDTH);

    spi_state_t       r_state;
    spi_state_t       w_nxt_state;
    logic [WIDTH-1:0] r_shreg;
    logic [c_RCW-1:0] r_rise_cnt;
    logic             r_miso_smp;
    logic             r_ss_n;
    logic             r_done;

    logic             w_rise;
    logic             w_fall;
    logic             w_run;
    logic             w_hold;
    logic             w_last_rise;
    logic             w_load;
    logic             w_shift;
    logic             w_finish;

    // All WIDTH bits have been sampled once the rise counter reaches WIDTH.
    assign w_last_rise = (r_rise_cnt == c_NBITS);
    assign w_run       = (r_state != IDLE);
    // Keep SCLK high from the boundary after the last rise through the back porch.
    assign w_hold      = ((r_state == SHIFT) && w_last_rise) || (r_state == BACK);

    spi_sclk_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_sclk_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_load),
        .i_run  (w_run),
        .i_hold (w_hold),
        .o_sclk (SCLK),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Next-state decode; every phase change happens on an SCLK fall boundary.
    always_comb begin
        w_nxt_state = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (wrt) begin
                    w_nxt_state = FRONT;
                    w_load      = 1'b1;
                end
            end
            FRONT: begin
                if (w_fall) begin
                    w_nxt_state = SHIFT;
                end
            end
            SHIFT: begin
                if (w_fall) begin
                    if (w_last_rise) begin
                        w_nxt_state = BACK;
                    end else begin
                        w_shift = 1'b1;
                    end
                end
            end
            BACK: begin
                if (w_fall) begin
                    w_shift     = 1'b1;
                    w_finish    = 1'b1;
                    w_nxt_state = IDLE;
                end
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    // Shift register: load the command, then shift left taking the MISO sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg <= '0;
        end else if (w_load) begin
            r_shreg <= cmd;
        end else if (w_shift) begin
            r_shreg <= {r_shreg[WIDTH-2:0], r_miso_smp};
        end
    end

    // MISO sample flop, captured on the clk where SCLK rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_miso_smp <= 1'b0;
        end else if (w_rise) begin
            r_miso_smp <= MISO;
        end
    end

    // Count SCLK rises within the frame to find the end of the data phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rise_cnt <= '0;
        end else if (w_load) begin
            r_rise_cnt <= '0;
        end else if (w_rise && (r_state == SHIFT)) begin
            r_rise_cnt <= r_rise_cnt + 1'b1;
        end
    end

    // Slave select and sticky done, both framed by load and finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ss_n <= 1'b1;
            r_done <= 1'b0;
        end else if (w_load) begin
            r_ss_n <= 1'b0;
            r_done <= 1'b0;
        end else if (w_finish) begin
            r_ss_n <= 1'b1;
            r_done <= 1'b1;
        end
    end

`ifdef SPI_MSTR_OVR_EN
    logic r_ovr;

    // Sticky overrun: any wrt while busy sets it, an accepted wrt clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr <= 1'b0;
        end else if (w_load) begin
            r_ovr <= 1'b0;
        end else if (wrt && (r_state != IDLE)) begin
            r_ovr <= 1'b1;
        end
    end

    assign ovr = r_ovr;
`endif

    assign SS_n    = r_ss_n;
    assign done    = r_done;
    assign MOSI    = r_shreg[WIDTH-1];
    assign rd_data = r_shreg;

endmodule : spi_mstr_gen
`default_nettype wire

// File: tb/tb_spi_mstr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_mstr_gen
// Description : Directed self-checking bench for spi_mstr_gen. One default
//               instance talks to a 16-bit mode-3 slave model (ADC128S-like);
//               a WIDTH=8, SCLK_DIV=4 instance runs with MISO looped to MOSI.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_mstr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        wrt;
    logic [15:0] cmd;
    wire         MISO;
    wire         SS_n;
    wire         SCLK;
    wire         MOSI;
    wire         done;
    wire  [15:0] rd_data;

    logic        wrt8;
    logic [7:0]  cmd8;
    wire         ss8;
    wire         sclk8;
    wire         mosi8;
    wire         done8;
    wire  [7:0]  rd8;
`ifdef SPI_MSTR_OVR_EN
    wire         ovr;
    wire         ovr8;
`endif

    spi_mstr_gen u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt),
        .cmd     (cmd),
        .MISO    (MISO),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
`ifdef SPI_MSTR_OVR_EN
        .ovr     (ovr),
`endif
        .done    (done),
        .rd_data (rd_data)
    );

    spi_mstr_gen #(
        .WIDTH    (8),
        .SCLK_DIV (4)
    ) u_dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt8),
        .cmd     (cmd8),
        .MISO    (mosi8),
        .SS_n    (ss8),
        .SCLK    (sclk8),
        .MOSI    (mosi8),
`ifdef SPI_MSTR_OVR_EN
        .ovr     (ovr8),
`endif
        .done    (done8),
        .rd_data (rd8)
    );

    // Slave model: loads its response while deselected, captures MOSI after
    // each SCLK rise and advances MISO after each fall that follows a rise.
    logic [15:0] slv_resp = 16'h0000;
    logic [15:0] s_tx     = 16'h0000;
    logic [15:0] s_rx     = 16'h0000;
    logic        s_sclk_q = 1'b1;
    int          s_nrise  = 0;
    int          n_rise   = 0;

    assign MISO = s_tx[15];

    always @(posedge clk) begin
        s_sclk_q <= SCLK;
        if (SCLK && !s_sclk_q) begin
            n_rise <= n_rise + 1;
        end
        if (SS_n) begin
            s_nrise <= 0;
            s_tx    <= slv_resp;
        end else begin
            if (SCLK && !s_sclk_q) begin
                s_rx    <= {s_rx[14:0], MOSI};
                s_nrise <= s_nrise + 1;
            end
            if (!SCLK && s_sclk_q && (s_nrise != 0)) begin
                s_tx <= {s_tx[14:0], 1'b0};
            end
        end
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pulse wrt for one edge; returns at the negedge after the sampling edge.
    task automatic launch(input logic [15:0] c);
        @(negedge clk);
        wrt = 1'b1;
        cmd = c;
        @(negedge clk);
        wrt = 1'b0;
    endtask

    // Count edges from the sampling edge until done is seen (bounded).
    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (!done && (cyc < 2000)) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run8(input logic [7:0] c, input string tag);
        int cyc;
        @(negedge clk);
        wrt8 = 1'b1;
        cmd8 = c;
        @(negedge clk);
        wrt8 = 1'b0;
        cyc  = 0;
        while (!done8 && (cyc < 500)) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_cyc"}, cyc, 36);
        chk({tag, "_rd"}, rd8, c);
        chk({tag, "_ss"}, ss8, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int r0;
        rst_n = 1'b0;
        wrt   = 1'b0;
        cmd   = 16'h0000;
        wrt8  = 1'b0;
        cmd8  = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_ss",    SS_n,    1'b1);
        chk("rst_sclk",  SCLK,    1'b1);
        chk("rst_done",  done,    1'b0);
        chk("rst_rd",    rd_data, 16'h0000);
        chk("rst_mosi",  MOSI,    1'b0);
        chk("rst_sclk8", sclk8,   1'b1);
        chk("rst_done8", done8,   1'b0);
`ifdef SPI_MSTR_OVR_EN
        chk("rst_ovr",   ovr,     1'b0);
`endif
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // All-zero command.
        slv_resp = 16'h5A3C;
        r0 = n_rise;
        launch(16'h0000);
        chk("z_ss_low", SS_n, 1'b0);
        wait_done(0, cyc);
        chk("z_cyc",   cyc,         544);
        chk("z_rx",    s_rx,        16'h0000);
        chk("z_rises", n_rise - r0, 16);
        chk("z_rd",    rd_data,     16'h5A3C);

        // Mixed pattern both ways, SS_n release and sticky done.
        slv_resp = 16'h1234;
        launch(16'hABCD);
        chk("a_mosi", MOSI, 1'b1);
        wait_done(0, cyc);
        chk("a_cyc", cyc,     544);
        chk("a_rx",  s_rx,    16'hABCD);
        chk("a_rd",  rd_data, 16'h1234);
        @(negedge clk);
        chk("a_ss_after", SS_n, 1'b1);
        repeat (20) @(negedge clk);
        chk("a_sticky",  done,    1'b1);
        chk("a_rd_hold", rd_data, 16'h1234);

        // wrt while busy is ignored.
        slv_resp = 16'hC3A5;
        launch(16'hABCD);
        repeat (99) @(negedge clk);
        wrt = 1'b1;
        cmd = 16'hFFFF;
        @(negedge clk);
        wrt = 1'b0;
        wait_done(100, cyc);
        chk("b_cyc", cyc,     544);
        chk("b_rx",  s_rx,    16'hABCD);
        chk("b_rd",  rd_data, 16'hC3A5);
`ifdef SPI_MSTR_OVR_EN
        chk("b_ovr", ovr, 1'b1);
`endif

        // Reset in the middle of a frame.
        slv_resp = 16'h0F0F;
        launch(16'h1357);
`ifdef SPI_MSTR_OVR_EN
        chk("c_ovr_clr", ovr, 1'b0);
`endif
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("c_ss",   SS_n,    1'b1);
        chk("c_sclk", SCLK,    1'b1);
        chk("c_done", done,    1'b0);
        chk("c_rd",   rd_data, 16'h0000);
        r0 = n_rise;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("c_no_edges", n_rise - r0, 0);
        chk("c_no_done",  done,        1'b0);
        slv_resp = 16'h8E71;
        r0 = n_rise;
        launch(16'h2468);
        wait_done(0, cyc);
        chk("c2_cyc",   cyc,         544);
        chk("c2_rx",    s_rx,        16'h2468);
        chk("c2_rd",    rd_data,     16'h8E71);
        chk("c2_rises", n_rise - r0, 16);

        // wrt on the done-setting cycle, held one more cycle.
        slv_resp = 16'h7E81;
        launch(16'h1111);
        repeat (543) @(negedge clk);
        wrt = 1'b1;
        cmd = 16'h2222;
        @(negedge clk);
        chk("d_done", done,    1'b1);
        chk("d_ss",   SS_n,    1'b1);
        chk("d_rx",   s_rx,    16'h1111);
        chk("d_rd",   rd_data, 16'h7E81);
        cmd      = 16'h3333;
        slv_resp = 16'h6C93;
        @(negedge clk);
        wrt = 1'b0;
        chk("d2_done_clr", done, 1'b0);
        chk("d2_ss_low",   SS_n, 1'b0);
        wait_done(0, cyc);
        chk("d2_cyc", cyc,     544);
        chk("d2_rx",  s_rx,    16'h3333);
        chk("d2_rd",  rd_data, 16'h6C93);
`ifdef SPI_MSTR_OVR_EN
        chk("d2_ovr", ovr, 1'b0);
`endif

        // Narrow instance with loopback.
        run8(8'hA5, "l_a5");
        run8(8'h3C, "l_3c");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_spi_mstr_gen
`default_nettype wire
